// File: rtl/meas_report_packer.sv
// meas_report_packer: buffers {id, data} counter records in a small FIFO and
// emits them as framed 64-bit words (header + two records per word) over a
// ready/valid link. Frames start on a full batch or after an idle timeout.
module meas_report_packer #(
   parameter int C_ID_WIDTH       = 12,
   parameter int C_COUNTER_WIDTH  = 20,
   parameter int C_FIFO_DEPTH     = 16,
   parameter int C_RECS_PER_FRAME = 8,
   parameter int C_TIMEOUT        = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [31:0]                in_time_p,
   input  logic                       in_dma_fifo_valid,
   input  logic [C_ID_WIDTH-1:0]      in_dma_fifo_id,
   input  logic [C_COUNTER_WIDTH-1:0] in_dma_fifo_data,
   output logic                       out_frame_valid,
   output logic [63:0]                out_frame_data,
   output logic                       out_frame_last,
   input  logic                       in_frame_ready,
   output logic                       out_fifo_full,
   output logic [15:0]                out_drop_cnt
);

   localparam int AW = $clog2(C_FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(C_TIMEOUT) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(C_FIFO_DEPTH);
   localparam logic [CW-1:0] RECS_C  = CW'(C_RECS_PER_FRAME);
   localparam logic [TW-1:0] TMAX_C  = TW'(C_TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

   // record storage; two combinational read ports feed the packed data word
   logic [31:0]   mem_reg [0:C_FIFO_DEPTH-1];

   state_t        state_reg, state_next;
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next, rd_base;
   logic [CW-1:0] count_reg, count_next, n_sel;
   logic [TW-1:0] timer_reg, timer_next;
   logic [7:0]    seq_reg, seq_next;
   logic [7:0]    left_reg, left_next;
   logic [1:0]    word_recs_reg, word_recs_next, pop_k;
   logic          valid_reg, valid_next;
   logic [63:0]   data_reg, data_next;
   logic          last_reg, last_next;
   logic          full_reg;
   logic [15:0]   drop_reg;
   logic          wr_en, drop_inc, hs, load_word;
   logic [31:0]   rec_a, rec_b, wr_rec;

   assign wr_rec   = {in_dma_fifo_id, in_dma_fifo_data};
   // the full decision looks only at registered occupancy, so a same-cycle pop never makes room
   assign wr_en    = in_dma_fifo_valid && (count_reg != DEPTH_C);
   assign drop_inc = in_dma_fifo_valid && (count_reg == DEPTH_C) && (drop_reg != 16'hFFFF);
   assign hs       = valid_reg && in_frame_ready;

   // read address for the next data word: the head, or two past it while a full word is being retired
   always_comb begin
      rd_base = (state_reg == S_DATA) ? rd_ptr_reg + AW'(2) : rd_ptr_reg;
      rec_a   = mem_reg[rd_base];
      rec_b   = mem_reg[rd_base + AW'(1)];
   end

   // frame FSM: next state, output word, pops, timer and sequence number
   always_comb begin
      state_next     = state_reg;
      valid_next     = valid_reg;
      data_next      = data_reg;
      last_next      = last_reg;
      left_next      = left_reg;
      word_recs_next = word_recs_reg;
      timer_next     = timer_reg;
      seq_next       = seq_reg;
      rd_ptr_next    = rd_ptr_reg;
      pop_k          = 2'd0;
      load_word      = 1'b0;
      n_sel          = (count_reg >= RECS_C) ? RECS_C : count_reg;

      case (state_reg)
         S_IDLE: begin
            valid_next = 1'b0;
            last_next  = 1'b0;
            timer_next = (count_reg != '0) ? timer_reg + TW'(1) : '0;
            if ((count_reg >= RECS_C) || ((count_reg != '0) && (timer_reg == TMAX_C))) begin
               state_next = S_HDR;
               timer_next = '0;
               left_next  = 8'(n_sel);
               valid_next = 1'b1;
               data_next  = {8'hA5, seq_reg, 8'(n_sel), 8'h00, in_time_p};
            end
         end
         S_HDR: begin
            if (hs) begin
               state_next = S_DATA;
               load_word  = 1'b1;
            end
         end
         S_DATA: begin
            if (hs) begin
               pop_k       = word_recs_reg;
               rd_ptr_next = rd_ptr_reg + AW'(word_recs_reg);
               if (last_reg) begin
                  state_next = S_IDLE;
                  valid_next = 1'b0;
                  last_next  = 1'b0;
                  seq_next   = seq_reg + 8'd1;
               end else begin
                  load_word = 1'b1;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase

      // pack the next one or two records; a lone final record leaves the low half zero
      if (load_word) begin
         if (left_reg >= 8'd2) begin
            data_next      = {rec_a, rec_b};
            word_recs_next = 2'd2;
            left_next      = left_reg - 8'd2;
         end else begin
            data_next      = {rec_a, 32'h0};
            word_recs_next = 2'd1;
            left_next      = left_reg - 8'd1;
         end
         last_next = (left_reg <= 8'd2);
      end

      count_next = count_reg + CW'(wr_en) - CW'(pop_k);
   end

   // record write port (storage carries no reset; pointers and count define validity)
   always_ff @(posedge clk) begin
      if (wr_en) mem_reg[wr_ptr_reg] <= wr_rec;
   end

   // state, pointers, counters and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= S_IDLE;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         timer_reg     <= '0;
         seq_reg       <= '0;
         left_reg      <= '0;
         word_recs_reg <= '0;
         valid_reg     <= 1'b0;
         data_reg      <= '0;
         last_reg      <= 1'b0;
         full_reg      <= 1'b0;
         drop_reg      <= '0;
      end else begin
         state_reg     <= state_next;
         if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         rd_ptr_reg    <= rd_ptr_next;
         count_reg     <= count_next;
         timer_reg     <= timer_next;
         seq_reg       <= seq_next;
         left_reg      <= left_next;
         word_recs_reg <= word_recs_next;
         valid_reg     <= valid_next;
         data_reg      <= data_next;
         last_reg      <= last_next;
         full_reg      <= (count_next == DEPTH_C);
         if (drop_inc) drop_reg <= drop_reg + 16'd1;
      end
   end

   assign out_frame_valid = valid_reg;
   assign out_frame_data  = data_reg;
   assign out_frame_last  = last_reg;
   assign out_fifo_full   = full_reg;
   assign out_drop_cnt    = drop_reg;

endmodule

// File: tb/tb_meas_report_packer.sv
// Directed bench for meas_report_packer: full batch, timeout flush, overflow,
// backpressure, sequence wrap and mid-frame reset.
`timescale 1ns/1ps
module tb_meas_report_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] in_time_p = '0;
   logic        in_dma_fifo_valid = 1'b0;
   logic [11:0] in_dma_fifo_id = '0;
   logic [19:0] in_dma_fifo_data = '0;
   logic        out_frame_valid;
   logic [63:0] out_frame_data;
   logic        out_frame_last;
   logic        in_frame_ready = 1'b0;
   logic        out_fifo_full;
   logic [15:0] out_drop_cnt;

   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   meas_report_packer dut (
      .clk               (clk),
      .rst               (rst),
      .in_time_p         (in_time_p),
      .in_dma_fifo_valid (in_dma_fifo_valid),
      .in_dma_fifo_id    (in_dma_fifo_id),
      .in_dma_fifo_data  (in_dma_fifo_data),
      .out_frame_valid   (out_frame_valid),
      .out_frame_data    (out_frame_data),
      .out_frame_last    (out_frame_last),
      .in_frame_ready    (in_frame_ready),
      .out_fifo_full     (out_fifo_full),
      .out_drop_cnt      (out_drop_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_rec(input logic [11:0] id, input logic [19:0] d);
      in_dma_fifo_valid = 1'b1;
      in_dma_fifo_id    = id;
      in_dma_fifo_data  = d;
      tick();
      in_dma_fifo_valid = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      total_cnt++;
      if (out_frame_valid !== 1'b0 || out_frame_data !== 64'h0 || out_frame_last !== 1'b0 ||
          out_fifo_full !== 1'b0 || out_drop_cnt !== 16'h0) begin
         $display("FAIL %s: valid=%b data=%h last=%b full=%b drop=%0d, expected all zero",
                  tag, out_frame_valid, out_frame_data, out_frame_last, out_fifo_full, out_drop_cnt);
      end else pass_cnt++;
   endtask

   // receive one frame with ready held high; records come from exp_q in order
   task automatic recv_frame(input string tag, input logic [7:0] exp_seq, input logic [7:0] exp_n,
                             input logic [31:0] exp_ts, input int hdr_budget);
      logic [63:0] exp_w;
      logic        exp_l;
      int          nwords;
      int          waited;
      in_frame_ready = 1'b1;
      waited = 0;
      while (!out_frame_valid && waited < hdr_budget) begin
         tick();
         waited++;
      end
      exp_w = {8'hA5, exp_seq, exp_n, 8'h00, exp_ts};
      total_cnt++;
      if (out_frame_valid !== 1'b1 || out_frame_data !== exp_w || out_frame_last !== 1'b0) begin
         $display("FAIL %s header: valid=%b data=%h last=%b, expected valid=1 data=%h last=0",
                  tag, out_frame_valid, out_frame_data, out_frame_last, exp_w);
         exp_q.delete();
         return;
      end else pass_cnt++;
      tick();
      nwords = (int'(exp_n) + 1) / 2;
      for (int w = 0; w < nwords; w++) begin
         exp_w[63:32] = exp_q.pop_front();
         if (w == nwords - 1 && exp_n[0]) exp_w[31:0] = 32'h0;
         else exp_w[31:0] = exp_q.pop_front();
         exp_l = (w == nwords - 1);
         total_cnt++;
         if (out_frame_valid !== 1'b1 || out_frame_data !== exp_w || out_frame_last !== exp_l) begin
            $display("FAIL %s word%0d: valid=%b data=%h last=%b, expected valid=1 data=%h last=%b",
                     tag, w + 1, out_frame_valid, out_frame_data, out_frame_last, exp_w, exp_l);
         end else pass_cnt++;
         tick();
      end
      total_cnt++;
      if (out_frame_valid !== 1'b0) begin
         $display("FAIL %s gap: valid=%b after last word, expected 0", tag, out_frame_valid);
      end else pass_cnt++;
      $display("%s: frame seq=%0d n=%0d words=%0d", tag, exp_seq, exp_n, nwords + 1);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick(); tick(); tick();
      check_outputs_zero("reset");
      rst = 1'b1;
      tick();
      $display("reset: released");
   endtask

   task automatic test_full_batch();
      in_time_p = 32'h1234_5678;
      in_frame_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         push_rec(12'(i), 20'(10 * i));
         exp_q.push_back({12'(i), 20'(10 * i)});
      end
      total_cnt++;
      if (out_frame_valid !== 1'b0) $display("FAIL full_batch early: valid=%b one cycle after last record, expected 0", out_frame_valid);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (out_frame_valid !== 1'b1) $display("FAIL full_batch latency: valid=%b two cycles after last record, expected 1", out_frame_valid);
      else pass_cnt++;
      recv_frame("full_batch", 8'd0, 8'd8, 32'h1234_5678, 0);
   endtask

   task automatic test_timeout();
      int waited;
      in_time_p = 32'hCAFE_0001;
      for (int i = 0; i < 3; i++) begin
         push_rec(12'h021 + 12'(i), 20'h00100 + 20'(i));
         exp_q.push_back({12'h021 + 12'(i), 20'h00100 + 20'(i)});
      end
      waited = 0;
      while (!out_frame_valid && waited < 1100) begin
         tick();
         waited++;
      end
      total_cnt++;
      if (waited !== 1022) $display("FAIL timeout latency: header after %0d cycles, expected 1022", waited);
      else pass_cnt++;
      recv_frame("timeout", 8'd1, 8'd3, 32'hCAFE_0001, 0);
   endtask

   task automatic test_overflow();
      in_time_p = 32'h0000_BEEF;
      in_frame_ready = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         push_rec(12'(i), 20'(3 * i));
         if (i <= 16) exp_q.push_back({12'(i), 20'(3 * i)});
         if (i == 15) begin
            total_cnt++;
            if (out_fifo_full !== 1'b0) $display("FAIL overflow full@15: full=%b, expected 0", out_fifo_full);
            else pass_cnt++;
         end
         if (i == 16) begin
            total_cnt++;
            if (out_fifo_full !== 1'b1) $display("FAIL overflow full@16: full=%b, expected 1", out_fifo_full);
            else pass_cnt++;
         end
      end
      total_cnt++;
      if (out_drop_cnt !== 16'd4 || out_fifo_full !== 1'b1)
         $display("FAIL overflow drops: drop=%0d full=%b, expected drop=4 full=1", out_drop_cnt, out_fifo_full);
      else pass_cnt++;
      recv_frame("overflow_a", 8'd2, 8'd8, 32'h0000_BEEF, 0);
      total_cnt++;
      if (out_fifo_full !== 1'b0) $display("FAIL overflow full_clear: full=%b, expected 0", out_fifo_full);
      else pass_cnt++;
      recv_frame("overflow_b", 8'd3, 8'd8, 32'h0000_BEEF, 4);
      for (int c = 0; c < 40; c++) begin
         if (out_frame_valid !== 1'b0) break;
         tick();
      end
      total_cnt++;
      if (out_frame_valid !== 1'b0) $display("FAIL overflow extra: valid=%b data=%h, expected no further frame", out_frame_valid, out_frame_data);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      logic [15:0] pat;
      logic [63:0] words_d [0:7];
      logic        words_l [0:7];
      logic [63:0] prev_d;
      logic        prev_l;
      logic        prev_stall;
      logic [63:0] exp_w;
      int          nw;
      logic        done;
      pat = 16'b1001_0110_0100_1101;
      in_time_p = 32'h0BAD_F00D;
      in_frame_ready = 1'b0;
      for (int i = 0; i < 8; i++) push_rec(12'h040 + 12'(i), 20'h05000 + 20'(i));
      nw = 0;
      prev_stall = 1'b0;
      prev_d = '0;
      prev_l = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
         if (prev_stall) begin
            total_cnt++;
            if (out_frame_valid !== 1'b1 || out_frame_data !== prev_d || out_frame_last !== prev_l)
               $display("FAIL backpressure hold: valid=%b data=%h last=%b, expected valid=1 data=%h last=%b",
                        out_frame_valid, out_frame_data, out_frame_last, prev_d, prev_l);
            else pass_cnt++;
         end
         in_frame_ready = pat[c % 16];
         if (out_frame_valid && in_frame_ready && nw < 8) begin
            words_d[nw] = out_frame_data;
            words_l[nw] = out_frame_last;
            nw++;
            if (out_frame_last) done = 1'b1;
         end
         prev_stall = out_frame_valid && !in_frame_ready;
         prev_d = out_frame_data;
         prev_l = out_frame_last;
         tick();
      end
      total_cnt++;
      if (nw !== 5) begin
         $display("FAIL backpressure count: %0d words accepted, expected 5", nw);
      end else begin
         pass_cnt++;
         for (int k = 0; k < 5; k++) begin
            if (k == 0) exp_w = {8'hA5, 8'd4, 8'd8, 8'h00, 32'h0BAD_F00D};
            else exp_w = {12'h040 + 12'(2 * k - 2), 20'h05000 + 20'(2 * k - 2),
                          12'h040 + 12'(2 * k - 1), 20'h05000 + 20'(2 * k - 1)};
            total_cnt++;
            if (words_d[k] !== exp_w || words_l[k] !== (k == 4))
               $display("FAIL backpressure word%0d: data=%h last=%b, expected data=%h last=%b",
                        k, words_d[k], words_l[k], exp_w, (k == 4));
            else pass_cnt++;
         end
      end
      $display("backpressure: frame seq=4 n=8 words=%0d", nw);
   endtask

   task automatic test_wrap_and_reset();
      int base;
      in_time_p = 32'h5EC0_0000;
      in_frame_ready = 1'b1;
      for (int f = 0; f < 260; f++) begin
         for (int j = 0; j < 8; j++) begin
            base = f * 8 + j;
            push_rec(12'(base), 20'(base + 7));
            exp_q.push_back({12'(base), 20'(base + 7)});
         end
         recv_frame("wrap", 8'(5 + f), 8'd8, 32'h5EC0_0000, 20);
      end
      // start a frame, then reset while data words are in flight
      for (int j = 0; j < 8; j++) push_rec(12'h070 + 12'(j), 20'h00777);
      for (int c = 0; c < 20; c++) begin
         if (out_frame_valid) break;
         tick();
      end
      tick();
      total_cnt++;
      if (out_frame_valid !== 1'b1 || out_frame_last !== 1'b0)
         $display("FAIL reset_mid setup: valid=%b last=%b, expected mid-frame valid=1 last=0", out_frame_valid, out_frame_last);
      else pass_cnt++;
      tick();
      rst = 1'b0;
      #1;
      check_outputs_zero("reset_mid");
      tick(); tick();
      rst = 1'b1;
      tick();
      in_time_p = 32'h0000_0042;
      for (int j = 0; j < 8; j++) begin
         push_rec(12'h080 + 12'(j), 20'h00900 + 20'(j));
         exp_q.push_back({12'h080 + 12'(j), 20'h00900 + 20'(j)});
      end
      recv_frame("after_reset", 8'd0, 8'd8, 32'h0000_0042, 20);
   endtask

   initial begin
      test_reset();
      test_full_batch();
      test_timeout();
      test_overflow();
      test_backpressure();
      test_wrap_and_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
